// File: rtl/fetch_unit_pkg.sv
// Shared core constants and the fetch buffer entry type.
package fetch_unit_pkg;
    localparam int              XLEN          = 32;
    localparam logic [XLEN-1:0] NOP_INSTR_DEF = 32'h0000_0013; // addi x0,x0,0
    localparam logic [XLEN-1:0] RESET_PC_DEF  = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory request/response bus. Fetch side is the master.
interface fetch_unit_if;
    import fetch_unit_pkg::*;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;

    modport master (output imem_req, imem_addr, input imem_gnt, imem_rvalid, imem_rdata);
    modport slave  (input imem_req, imem_addr, output imem_gnt, imem_rvalid, imem_rdata);
endinterface

// File: rtl/fetch_unit_fifo.sv
// fetch_fifo: DEPTH-entry {pc,instr} buffer between imem responses and the IF/ID register.
// Clear dominates push/pop; DEPTH must be a power of two so pointers wrap naturally.
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clear,
    input  logic         i_push,
    input  logic         i_pop,
    input  fetch_entry_t i_data,
    output fetch_entry_t o_head,
    output logic [CW-1:0] o_count
);
    fetch_entry_t  r_mem [DEPTH];
    logic [PW-1:0] r_rd_ptr, r_wr_ptr;
    logic [CW-1:0] r_count;

    // Storage write; contents need no reset since count qualifies them
    always_ff @(posedge clk) begin
        if (i_push && !i_clear) r_mem[r_wr_ptr] <= i_data;
    end

    // Pointer and occupancy tracking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: IF stage + IF/ID register. Owns PCF, issues in-order imem requests under a
// credit limit (buffered + outstanding < DEPTH), discards responses made stale by a redirect.
// Optional: FETCH_PERF_CNT_EN adds StarveCnt/RedirectCnt outputs.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEF,
    parameter int              DEPTH     = 2,
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            StallF,
    input  logic            StallD,
    input  logic            FlushD,
    input  logic            PCSrcE,
    input  logic [XLEN-1:0] PCTargetE,
    fetch_unit_if.master    imem,
    output logic [XLEN-1:0] InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic            ValidD
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     StarveCnt,
    output logic [31:0]     RedirectCnt
`endif
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic [XLEN-1:0] r_pcf;
    logic [CW-1:0]   r_outst, r_drop;
    logic [XLEN-1:0] r_pcq [DEPTH];
    logic [PW-1:0]   r_pcq_wr, r_pcq_rd;
    logic [XLEN-1:0] r_instr_d, r_pc_d, r_pcp4_d;
    logic            r_valid_d;

    logic            w_credit, w_fire, w_push, w_pop, w_drop_rsp;
    logic [CW-1:0]   w_count;
    fetch_entry_t    w_head, w_push_data;

    assign w_credit   = ((CW+1)'(w_count) + (CW+1)'(r_outst)) < (CW+1)'(DEPTH);
    assign imem.imem_req  = !rst && !PCSrcE && !StallF && w_credit;
    assign imem.imem_addr = r_pcf;
    assign w_fire     = imem.imem_req && imem.imem_gnt;
    assign w_drop_rsp = imem.imem_rvalid && (r_drop != '0);
    // A response landing in the redirect cycle is wrong-path too, so it is never pushed
    assign w_push     = imem.imem_rvalid && (r_drop == '0) && !PCSrcE;
    assign w_pop      = !FlushD && !StallD && (w_count != '0);
    assign w_push_data = '{pc: r_pcq[r_pcq_rd], instr: imem.imem_rdata};

    // PCF advance/redirect, outstanding credit and stale-response drop count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pcf   <= RESET_PC;
            r_outst <= '0;
            r_drop  <= '0;
        end else begin
            r_outst <= r_outst + CW'(w_fire) - CW'(imem.imem_rvalid);
            if (PCSrcE) begin
                r_pcf  <= PCTargetE;
                r_drop <= r_outst - CW'(imem.imem_rvalid);
            end else begin
                if (w_fire)     r_pcf  <= r_pcf + 32'd4;
                if (w_drop_rsp) r_drop <= r_drop - 1'b1;
            end
        end
    end

    // PC of each live request, captured at grant, consumed when its word is buffered
    always_ff @(posedge clk) begin
        if (w_fire) r_pcq[r_pcq_wr] <= r_pcf;
    end

    // PC queue pointers; redirect discards all pending live PCs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pcq_wr <= '0;
            r_pcq_rd <= '0;
        end else if (PCSrcE) begin
            r_pcq_wr <= '0;
            r_pcq_rd <= '0;
        end else begin
            if (w_fire) r_pcq_wr <= r_pcq_wr + 1'b1;
            if (w_push) r_pcq_rd <= r_pcq_rd + 1'b1;
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_clear (PCSrcE),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_push_data),
        .o_head  (w_head),
        .o_count (w_count)
    );

    // IF/ID register: flush > stall > pop head > bubble; PCs are held across bubbles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_instr_d <= NOP_INSTR;
            r_pc_d    <= '0;
            r_pcp4_d  <= 32'd4;
            r_valid_d <= 1'b0;
        end else if (FlushD) begin
            r_instr_d <= NOP_INSTR;
            r_valid_d <= 1'b0;
        end else if (!StallD) begin
            if (w_count != '0) begin
                r_instr_d <= w_head.instr;
                r_pc_d    <= w_head.pc;
                r_pcp4_d  <= w_head.pc + 32'd4;
                r_valid_d <= 1'b1;
            end else begin
                r_instr_d <= NOP_INSTR;
                r_valid_d <= 1'b0;
            end
        end
    end

    assign InstrD   = r_instr_d;
    assign PCD      = r_pc_d;
    assign PCPlus4D = r_pcp4_d;
    assign ValidD   = r_valid_d;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_starve, r_redirect;

    // Starvation (decode wanted a word, none buffered) and redirect event counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve   <= '0;
            r_redirect <= '0;
        end else begin
            if (!FlushD && !StallD && (w_count == '0)) r_starve <= r_starve + 32'd1;
            if (PCSrcE) r_redirect <= r_redirect + 32'd1;
        end
    end

    assign StarveCnt   = r_starve;
    assign RedirectCnt = r_redirect;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: imem model with configurable latency/grant, scoreboard of expected
// {pc,instr} pushed at grant and popped on each fresh decode load, plus a cycle table.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        StallF = 1'b0, StallD = 1'b0, FlushD = 1'b0, PCSrcE = 1'b0;
    logic [31:0] PCTargetE = 32'h0;
    logic [31:0] InstrD, PCD, PCPlus4D;
    logic        ValidD;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] StarveCnt, RedirectCnt;
`endif

    fetch_unit_if imem();

    fetch_unit dut (
        .clk(clk), .rst(rst), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .imem(imem),
        .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD)
`ifdef FETCH_PERF_CNT_EN
        , .StarveCnt(StarveCnt), .RedirectCnt(RedirectCnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int due; } mreq_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;
    typedef struct { logic stalld; logic exp_req; logic [31:0] exp_addr;
                     logic exp_v; logic [31:0] exp_pcd; } row_t;

    mreq_t       mq[$];
    exp_t        sb[$];
    logic [31:0] model_pc = 32'h0;
    int          lat_fixed = 1;
    bit          lat_rand = 0, gnt_rand = 0;
    int          n_cmp = 0, n_err = 0;
    int          n_pops = 0;
    bit          saw_wrap = 0;
    logic [31:0] last_pc = 32'h0;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'h5A00_0003;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    // Instruction memory: in-order responses, latency >= 1 after grant
    initial begin : mem
        int cyc, last_due, d;
        bit popping;
        cyc = 0; last_due = 0;
        imem.imem_gnt = 1'b0; imem.imem_rvalid = 1'b0; imem.imem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            cyc++;
            popping = 0;
            imem.imem_gnt = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            if (mq.size() > 0 && mq[0].due <= cyc) begin
                imem.imem_rvalid = 1'b1;
                imem.imem_rdata  = word_of(mq[0].addr);
                popping = 1;
            end else begin
                imem.imem_rvalid = 1'b0;
                imem.imem_rdata  = 32'h0;
            end
            #4;
            if (rst) begin
                mq.delete();
                last_due = cyc;
            end else begin
                if (popping) void'(mq.pop_front());
                if (imem.imem_req && imem.imem_gnt) begin
                    chk("issue_addr", imem.imem_addr, model_pc);
                    d = cyc + (lat_rand ? int'($urandom_range(1, 4)) : lat_fixed);
                    if (d <= last_due) d = last_due + 1;
                    last_due = d;
                    mq.push_back('{imem.imem_addr, d});
                    sb.push_back('{model_pc, word_of(model_pc)});
                    model_pc = model_pc + 32'd4;
                end
            end
        end
    end

    // Decode-side monitor: checks every edge's IF/ID outcome
    initial begin : mon
        logic sd, fd, r0, p_v;
        logic [31:0] p_instr, p_pcd, p_pcp4;
        exp_t e;
        p_v = 0; p_instr = 0; p_pcd = 0; p_pcp4 = 0;
        forever begin
            @(posedge clk);
            sd = StallD; fd = FlushD; r0 = rst;
            #1;
            if (!r0 && !rst) begin
                if (fd) begin
                    chk("flush_valid", ValidD, 32'd0);
                    chk("flush_instr", InstrD, 32'h13);
                end else if (sd) begin
                    chk("hold_instr", InstrD, p_instr);
                    chk("hold_pcd", PCD, p_pcd);
                    chk("hold_pcp4", PCPlus4D, p_pcp4);
                    chk("hold_valid", ValidD, p_v);
                end else if (ValidD) begin
                    if (sb.size() == 0) begin
                        n_cmp++; n_err++;
                        $display("FAIL sb_underflow: decode got PCD %h, required no instruction", PCD);
                    end else begin
                        e = sb.pop_front();
                        chk("sb_pcd", PCD, e.pc);
                        chk("sb_instr", InstrD, e.instr);
                        chk("sb_pcp4", PCPlus4D, e.pc + 32'd4);
                        if (e.pc == 32'h0 && last_pc == 32'hFFFF_FFFC) saw_wrap = 1;
                        last_pc = e.pc;
                        n_pops++;
                    end
                end else begin
                    chk("bubble_instr", InstrD, 32'h13);
                end
            end
            p_v = ValidD; p_instr = InstrD; p_pcd = PCD; p_pcp4 = PCPlus4D;
        end
    end

    // Enter reset at the current negedge, check reset state, release two edges later
    task automatic do_reset();
        rst = 1'b1;
        StallF = 0; StallD = 0; FlushD = 0; PCSrcE = 0; PCTargetE = 32'h0;
        sb.delete();
        model_pc = 32'h0;
        #2;
        chk("rst_req", imem.imem_req, 32'd0);
        chk("rst_addr", imem.imem_addr, 32'h0);
        chk("rst_instr", InstrD, 32'h13);
        chk("rst_pcd", PCD, 32'h0);
        chk("rst_pcp4", PCPlus4D, 32'h4);
        chk("rst_valid", ValidD, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        bit ok;
        ok = 0;
        for (int i = 0; i < 30 && !ok; i++) begin
            @(posedge clk); #1;
            ok = ValidD;
        end
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s_timeout: ValidD 0 for 30 cycles, required 1", name);
        end
        @(negedge clk);
    endtask

    task automatic redirect(input logic [31:0] tgt);
        PCSrcE = 1; FlushD = 1; PCTargetE = tgt;
        sb.delete();
        model_pc = tgt;
    endtask

    row_t tbl[13];

    initial begin : test
        // Reset release, 1-cycle latency, then StallD x3 while the buffer fills
        tbl[0]  = '{1'b0, 1'b1, 32'd0,  1'b0, 32'd0};
        tbl[1]  = '{1'b0, 1'b1, 32'd4,  1'b0, 32'd0};
        tbl[2]  = '{1'b0, 1'b0, 32'd8,  1'b1, 32'd0};
        tbl[3]  = '{1'b0, 1'b1, 32'd8,  1'b1, 32'd4};
        tbl[4]  = '{1'b0, 1'b1, 32'd12, 1'b0, 32'd0};
        tbl[5]  = '{1'b0, 1'b0, 32'd16, 1'b1, 32'd8};
        tbl[6]  = '{1'b0, 1'b1, 32'd16, 1'b1, 32'd12};
        tbl[7]  = '{1'b1, 1'b1, 32'd20, 1'b1, 32'd12};
        tbl[8]  = '{1'b1, 1'b0, 32'd24, 1'b1, 32'd12};
        tbl[9]  = '{1'b1, 1'b0, 32'd24, 1'b1, 32'd12};
        tbl[10] = '{1'b0, 1'b0, 32'd24, 1'b1, 32'd16};
        tbl[11] = '{1'b0, 1'b1, 32'd24, 1'b1, 32'd20};
        tbl[12] = '{1'b0, 1'b1, 32'd28, 1'b0, 32'd0};

        @(negedge clk);
        lat_fixed = 1; gnt_rand = 0; lat_rand = 0;
        do_reset();
        for (int k = 0; k < 13; k++) begin
            StallD = tbl[k].stalld;
            #4;
            chk($sformatf("tbl%0d_req", k), imem.imem_req, tbl[k].exp_req);
            chk($sformatf("tbl%0d_addr", k), imem.imem_addr, tbl[k].exp_addr);
            @(posedge clk); #1;
            chk($sformatf("tbl%0d_valid", k), ValidD, tbl[k].exp_v);
            if (tbl[k].exp_v) chk($sformatf("tbl%0d_pcd", k), PCD, tbl[k].exp_pcd);
            @(negedge clk);
        end

        // Redirect with two requests outstanding: both responses must be discarded
        lat_fixed = 3;
        do_reset();
        @(negedge clk);
        @(negedge clk);
        redirect(32'h100);
        #4;
        chk("t3_req_in_redirect", imem.imem_req, 32'd0);
        @(negedge clk);
        PCSrcE = 0; FlushD = 0;
        #4;
        chk("t3_addr_target", imem.imem_addr, 32'h100);
        wait_valid("t3");
        chk("t3_first_pcd", PCD, 32'h100);

        // Redirect together with StallF: redirect wins
        StallF = 1;
        redirect(32'h200);
        #4;
        chk("t4_req_in_redirect", imem.imem_req, 32'd0);
        @(negedge clk);
        PCSrcE = 0; FlushD = 0;
        #4;
        chk("t4_addr_target", imem.imem_addr, 32'h200);
        chk("t4_req_stallf", imem.imem_req, 32'd0);
        @(negedge clk);
        StallF = 0;
        wait_valid("t4");
        chk("t4_first_pcd", PCD, 32'h200);

        // FlushD beats StallD
        StallD = 1; FlushD = 1;
        @(posedge clk); #1;
        chk("t5_instr", InstrD, 32'h13);
        chk("t5_valid", ValidD, 32'd0);
        @(negedge clk);
        StallD = 0; FlushD = 0;

        // Random grant/latency/stalls across the 2^32 wrap
        lat_rand = 1; gnt_rand = 1;
        redirect(32'hFFFF_FFF0);
        @(negedge clk);
        PCSrcE = 0; FlushD = 0;
        n_pops = 0; saw_wrap = 0;
        repeat (400) begin
            StallF = ($urandom_range(0, 3) == 0);
            StallD = ($urandom_range(0, 3) == 0);
            FlushD = ($urandom_range(0, 7) == 0);
            @(negedge clk);
        end
        StallF = 0; StallD = 0; FlushD = 0;
        repeat (20) @(negedge clk);
        chk("t6_wrap_seen", saw_wrap, 32'd1);
        chk("t6_progress", (n_pops >= 20), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
